// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU sequencer: FSM encoding, pipeline depth and
// the per-read tag that travels down the S0/S1 shift stages.
package sfu_pkg;

    localparam int unsigned SFU_PIPE_LAT = 2;

    localparam int unsigned ST_W     = 2;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;

    // Side information for one psum read, carried alongside the SRAM data.
    typedef struct packed {
        logic rd;     // a read was issued this cycle
        logic byp;    // pass-through mode
        logic first;  // first tap of an output row
        logic last;   // last tap of an output row (triggers write-back)
    } sfu_tag_t;

endpackage

// File: rtl/sfu_seq_ctrl_if.sv
// Control/handshake bundle between the core FSM, psum SRAM, sfu and output SRAM
// and the sequencer. slave = sequencer side, master = environment side.
interface sfu_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 5
);
    logic              start_i;
    logic [LEN_W-1:0]  cfg_len_i;
    logic              cfg_bypass_i;
    logic              out_ready_i;
    logic              psum_rd_o;
    logic [ADDR_W-1:0] psum_addr_o;
    logic              acc_o;
    logic              psum_bypass_o;
    logic              acc_clr_o;
    logic              out_wr_o;
    logic [ADDR_W-1:0] out_addr_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  start_i, cfg_len_i, cfg_bypass_i, out_ready_i,
        output psum_rd_o, psum_addr_o, acc_o, psum_bypass_o, acc_clr_o,
               out_wr_o, out_addr_o, busy_o, done_o
    );

    modport master (
        output start_i, cfg_len_i, cfg_bypass_i, out_ready_i,
        input  psum_rd_o, psum_addr_o, acc_o, psum_bypass_o, acc_clr_o,
               out_wr_o, out_addr_o, busy_o, done_o
    );
endinterface

// File: rtl/sfu_addr_gen.sv
// Tap-major psum address walker. Address is base+o with base stepping by N
// per tap, so no multiplier is needed; overflow wraps modulo 2^ADDR_W.
module sfu_addr_gen
    import sfu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned NUM_KIJ = 9,
    parameter int unsigned LEN_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              adv,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              bypass,
    output logic [ADDR_W-1:0] addr_c,
    output logic [LEN_W-1:0]  oidx_c,
    output logic              first_c,
    output logic              row_end_c,
    output logic              last_c
);
    localparam int unsigned     K_W    = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;
    localparam logic [K_W-1:0]  K_LAST = K_W'(NUM_KIJ - 1);

    logic [K_W-1:0]    k_q;
    logic [LEN_W-1:0]  o_q;
    logic [ADDR_W-1:0] base_q;

    // Row/run position decode for the read about to be issued.
    always_comb begin
        addr_c    = base_q + ADDR_W'(o_q);
        oidx_c    = o_q;
        first_c   = bypass || (k_q == '0);
        row_end_c = bypass || (k_q == K_LAST);
        last_c    = row_end_c && (o_q == (cfg_len - LEN_W'(1)));
    end

    // Step tap counter and base per read; move to the next output at row end.
    always_ff @(posedge clk) begin
        if (reset || init) begin
            k_q    <= '0;
            o_q    <= '0;
            base_q <= '0;
        end else if (adv) begin
            if (row_end_c) begin
                k_q    <= '0;
                base_q <= '0;
                o_q    <= o_q + LEN_W'(1);
            end else begin
                k_q    <= k_q + K_W'(1);
                base_q <= base_q + ADDR_W'(cfg_len);
            end
        end
    end

endmodule

// File: rtl/sfu_seq_ctrl.sv
// SFU accumulation sequencer: FSM, read issue gating and the S0/S1/S2 stages
// that align acc/bypass/clear with psum data and issue output write-backs.
// Optional build macro SFU_CTRL_PERF_EN adds the perf_cycles_o busy counter.
module sfu_seq_ctrl
    import sfu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned NUM_KIJ = 9,
    parameter int unsigned LEN_W   = 5
) (
    input  logic            clk,
    input  logic            reset,
    sfu_seq_ctrl_if.slave   bus
`ifdef SFU_CTRL_PERF_EN
    ,
    output logic [15:0]     perf_cycles_o
`endif
);
    localparam int unsigned DRN_W = (SFU_PIPE_LAT > 1) ? $clog2(SFU_PIPE_LAT) : 1;

    logic [ST_W-1:0]   state_q, state_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              accept_c;
    logic              issue_c;

    logic [LEN_W-1:0]  cfg_len_q;
    logic              cfg_byp_q;

    logic [ADDR_W-1:0] addr_c;
    logic [LEN_W-1:0]  oidx_c;
    logic              first_c;
    logic              row_end_c;
    logic              last_c;

    sfu_tag_t          s0_tag_q;
    logic [ADDR_W-1:0] s0_oidx_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              acc_q, byp_q, clr_q;
    logic              s1_wr_q;
    logic [ADDR_W-1:0] s1_oidx_q;
    logic              wr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              busy_q, done_q;

    sfu_addr_gen #(
        .ADDR_W  (ADDR_W),
        .NUM_KIJ (NUM_KIJ),
        .LEN_W   (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .init      (accept_c),
        .adv       (issue_c),
        .cfg_len   (cfg_len_q),
        .bypass    (cfg_byp_q),
        .addr_c    (addr_c),
        .oidx_c    (oidx_c),
        .first_c   (first_c),
        .row_end_c (row_end_c),
        .last_c    (last_c)
    );

    // FSM state and drain counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next state, start acceptance and row-gated read issue.
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        accept_c = 1'b0;
        issue_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    accept_c = 1'b1;
                    state_d  = (bus.cfg_len_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue_c = !first_c || bus.out_ready_i;
                if (issue_c && last_c) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(SFU_PIPE_LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Configuration is captured on start accept and frozen for the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_len_q <= '0;
            cfg_byp_q <= 1'b0;
        end else if (accept_c) begin
            cfg_len_q <= bus.cfg_len_i;
            cfg_byp_q <= bus.cfg_bypass_i;
        end
    end

    // S0 read issue, S1 sfu controls, S2 write-back, plus status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_tag_q   <= '0;
            s0_oidx_q  <= '0;
            rd_addr_q  <= '0;
            acc_q      <= 1'b0;
            byp_q      <= 1'b0;
            clr_q      <= 1'b0;
            s1_wr_q    <= 1'b0;
            s1_oidx_q  <= '0;
            wr_q       <= 1'b0;
            out_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            s0_tag_q   <= '{rd: issue_c, byp: cfg_byp_q, first: first_c, last: row_end_c};
            s0_oidx_q  <= ADDR_W'(oidx_c);
            rd_addr_q  <= addr_c;
            acc_q      <= s0_tag_q.rd && !s0_tag_q.byp;
            byp_q      <= s0_tag_q.rd && s0_tag_q.byp;
            clr_q      <= s0_tag_q.rd && !s0_tag_q.byp && s0_tag_q.first;
            s1_wr_q    <= s0_tag_q.rd && s0_tag_q.last;
            s1_oidx_q  <= s0_oidx_q;
            wr_q       <= s1_wr_q;
            out_addr_q <= s1_oidx_q;
            busy_q     <= (state_q != ST_IDLE);
            done_q     <= (state_q == ST_DONE);
        end
    end

    assign bus.psum_rd_o     = s0_tag_q.rd;
    assign bus.psum_addr_o   = rd_addr_q;
    assign bus.acc_o         = acc_q;
    assign bus.psum_bypass_o = byp_q;
    assign bus.acc_clr_o     = clr_q;
    assign bus.out_wr_o      = wr_q;
    assign bus.out_addr_o    = out_addr_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;

`ifdef SFU_CTRL_PERF_EN
    // Busy-cycle counter for the most recent run; saturates, holds after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_o <= '0;
        end else if (accept_c) begin
            perf_cycles_o <= '0;
        end else if (busy_q && (perf_cycles_o != 16'hFFFF)) begin
            perf_cycles_o <= perf_cycles_o + 16'd1;
        end
    end
`endif

endmodule
